// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: stage-register state encoding
// and the default payload width.
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_FULL  = 2'd1,
        PS_SKID  = 2'd2
    } ps_state_t;

    localparam int PIPE_WIDTH = 16;

endpackage

// File: rtl/pipe_stage_reg_en_reg.sv
// WIDTH-bit enable register, async active-high reset and a
// synchronous clear, both returning to RESET_VAL.
module en_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = PIPE_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Clear wins over load; otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= RESET_VAL;
        end else if (i_clr) begin
            r_q <= RESET_VAL;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake and a
// one-entry skid buffer; in_ready is decoded from state only.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = PIPE_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    ps_state_t        r_state;
    ps_state_t        w_state_nxt;
    logic             w_main_en;
    logic             w_main_from_skid;
    logic             w_skid_en;
    logic [WIDTH-1:0] w_main_d;
    logic [WIDTH-1:0] w_main_q;
    logic [WIDTH-1:0] w_skid_q;

    // Next state and register load enables; flush overrides all.
    always_comb begin
        w_state_nxt      = r_state;
        w_main_en        = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_en        = 1'b0;
        if (!flush) begin
            unique case (r_state)
                PS_EMPTY: begin
                    if (in_valid) begin
                        w_main_en   = 1'b1;
                        w_state_nxt = PS_FULL;
                    end
                end
                PS_FULL: begin
                    if (in_valid && out_ready) begin
                        w_main_en = 1'b1;
                    end else if (out_ready) begin
                        w_state_nxt = PS_EMPTY;
                    end else if (in_valid) begin
                        w_skid_en   = 1'b1;
                        w_state_nxt = PS_SKID;
                    end
                end
                PS_SKID: begin
                    if (out_ready) begin
                        w_main_en        = 1'b1;
                        w_main_from_skid = 1'b1;
                        w_state_nxt      = PS_FULL;
                    end
                end
                default: begin
                    w_state_nxt = PS_EMPTY;
                end
            endcase
        end
    end

    // Occupancy state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= PS_EMPTY;
        end else if (flush) begin
            r_state <= PS_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_main_d = w_main_from_skid ? w_skid_q : in_data;

    en_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_main (
        .clk   (clk),
        .rst   (rst),
        .i_clr (flush),
        .i_en  (w_main_en),
        .i_d   (w_main_d),
        .o_q   (w_main_q)
    );

    en_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .i_clr (flush),
        .i_en  (w_skid_en),
        .i_d   (in_data),
        .o_q   (w_skid_q)
    );

    // Handshake outputs decoded from state.
    always_comb begin
        occupancy = 2'd0;
        unique case (r_state)
            PS_FULL:  occupancy = 2'd1;
            PS_SKID:  occupancy = 2'd2;
            default:  occupancy = 2'd0;
        endcase
    end

    assign out_valid = (r_state != PS_EMPTY);
    assign in_ready  = (r_state != PS_SKID) & ~flush;
    assign out_data  = w_main_q;

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with a valid/ready handshake and a one-entry skid buffer. It is the successor to the single-bit enable/reset flip-flops: the width and reset value are generic, and it adds stall-tolerant flow control and a synchronous flush. It sits between CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It gives full throughput with a registered `in_ready`, so no combinational ready path crosses stages.

## Interface
- `WIDTH`, 16: payload width in bits (≥1).
- `RESET_VAL`, 0: value loaded into both data registers on reset and on flush.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `flush` input 1: synchronous squash of all held entries.
- `in_valid` input 1: upstream presents `in_data`.
- `in_ready` output 1: stage can accept; transfer occurs when `in_valid & in_ready` at a rising edge.
- `in_data` input WIDTH: upstream payload.
- `out_valid` output 1: `out_data` holds a valid entry.
- `out_ready` input 1: downstream accepts; transfer occurs when `out_valid & out_ready` at a rising edge.
- `out_data` output WIDTH: head payload, driven directly from the main register.
- `occupancy` output 2: number of held entries, 0..2.

## Operation
- State machine has three states:
  - EMPTY: main invalid.
  - FULL: main valid, skid invalid.
  - SKID: main and skid both valid.
- Outputs are decoded from state only:
  - `out_valid = (state != EMPTY)`.
  - `in_ready = (state != SKID) & ~flush`.
  - `occupancy` = 0 in EMPTY, 1 in FULL, 2 in SKID.
- Transitions, evaluated when `flush=0`:
  - EMPTY, `in_valid`: main ← `in_data`; go to FULL.
  - FULL, `in_valid & out_ready`: main ← `in_data`; stay in FULL.
  - FULL, `~in_valid & out_ready`: go to EMPTY.
  - FULL, `in_valid & ~out_ready`: skid ← `in_data`; go to SKID.
  - SKID, `out_ready`: main ← skid; go to FULL. `in_ready` is 0 in this state, so no input is taken.
  - Any other combination: hold state and data.
- Flush has priority over every transition:
  - Next state is EMPTY; main and skid are loaded with `RESET_VAL`.
  - Because `in_ready` is forced to 0, no input transfer occurs.
  - An output transfer on that edge still counts downstream; the held data is simply discarded afterwards.
- Data registers load only on the events listed above. They never change in any other case, including bubble cycles.
- Ordering: entries leave in the order they arrived. The skid entry is always younger than the main entry.

## Timing
- Reset (asynchronous, on `rst` rising):
  - State is EMPTY; main and skid equal `RESET_VAL`.
  - `out_valid`=0, `occupancy`=0, `out_data`=`RESET_VAL`.
  - `in_ready`=1, but no transfer is taken while `rst` is high.
- Latency: an input accepted at edge N appears on `out_data`/`out_valid` after edge N. With `out_ready` held at 1, the stage sustains one transfer per cycle.
- Downstream stall: after `out_ready` drops, the stage absorbs exactly one more entry, then `in_ready` falls one cycle later (registered). No data is lost or duplicated.
- Stall release from SKID: on the first `out_ready` edge the main entry leaves. `in_ready` returns to 1 in the following cycle.
- Flush together with `rst`: reset dominates.
- Reset asserted mid-transfer: the in-flight data is discarded, with no partial update.

## Structure
- Shared package `pipe_pkg` holds:
  - the state enum typedef (`PS_EMPTY`, `PS_FULL`, `PS_SKID`, 2-bit encoding);
  - the default pipeline payload width constant (16).
- One sub-module, `en_reg`: a WIDTH-bit enable register with asynchronous active-high reset to a parametrised value. It is instantiated twice (main and skid), and its behaviour generalises the existing bit-level flip-flops.
- All next-state and load-enable logic stays in `pipe_stage_reg`.

## Test plan
- Reset and streaming: assert `rst`, release it, then drive 0x0001..0x0008 on consecutive cycles with `out_ready`=1. The output shows the same sequence, one cycle delayed. `occupancy` stays ≤1 and `in_ready` stays 1.
- Backpressure:
  - Drive 0x00A1 then 0x00A2 while `out_ready`=0. `occupancy` goes to 2 and `in_ready` drops to 0.
  - Raise `out_ready`. The output is 0x00A1, then 0x00A2, then `out_valid`=0.
- Flush in SKID: fill with 0x1111 and 0x2222, then pulse `flush` for one cycle. The next cycle shows `out_valid`=0, `occupancy`=0, `out_data`=`RESET_VAL`, and `in_ready`=1.
- Flush with `in_valid`: assert `in_valid` with 0x3333 in the same cycle as `flush`, from EMPTY. The value is not accepted and `out_valid` stays 0.
- Asynchronous reset mid-stall: with the stage in SKID, assert `rst` between clock edges. The outputs immediately return to their reset values, without waiting for a clock edge.
- Random scoreboard: 10k cycles with random `in_valid`/`out_ready`, with WIDTH=32 and RESET_VAL=0xDEADBEEF. Check that there is no loss, duplication or reordering, and that `occupancy` always matches the scoreboard count.
